qspi_apb_regs: RTL
==================

# qspi_apb_regs

APB completer for the QSPI flash controller. It answers the transfers issued by our single-transaction APB master and inserts a programmable number of wait states. It holds the controller's register file (control, flash address, command, IRQ) plus TX/RX data FIFOs that sit between the bus and the QSPI core, and it drives the control/command outputs consumed by the QSPI engine.

## Interface
- WAIT_CYCLES, 0: wait states inserted in the access phase (0..15).
- FIFO_DEPTH, 4: TX and RX FIFO depth, power of two, 2..16.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  12  byte address; [1:0] ignored.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid when pready=1.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response, valid with pready.
- ctrl_o  out  8  CTRL register.
- flash_addr_o  out  24  ADDR register.
- cmd_o  out  8  last accepted opcode.
- cmd_start_o  out  1  one-cycle pulse per accepted CMD write.
- core_busy_i, core_done_i  in  1 each  engine busy level / done pulse.
- tx_rd_i  in  1; tx_data_o  out  32; tx_empty_o  out  1  core-side TX pop.
- rx_wr_i  in  1; rx_data_i  in  32; rx_full_o  out  1  core-side RX push.
- irq_o  out  1  interrupt.

## Operation
- FSM: IDLE, ACCESS.
  - IDLE: psel & ~penable is a setup phase. Go to ACCESS, load wait counter with WAIT_CYCLES, and snapshot read data into prdata.
  - ACCESS: while cnt≠0, decrement with pready=0. When cnt=0 and psel&penable, pready=1. Side effects commit on that edge, then return to IDLE.
  - psel dropped while in ACCESS: return to IDLE, no side effects.
- Register map (paddr[11:2]):
  - 0x000 CTRL RW [7:0]: [0] enable, [1] quad, [2] irq_en, [7:4] dummy cycles.
  - 0x004 STATUS RO: [0] core_busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [12:8] tx level, [20:16] rx level.
  - 0x008 ADDR RW [23:0].
  - 0x00C CMD RW [7:0]:
    - Write with core_busy_i=0: update cmd_o, pulse cmd_start_o in the cycle after completion.
    - Write with core_busy_i=1: rejected, error.
  - 0x010 TXDATA WO: push. Push when full is dropped with error. Read returns 0 with error.
  - 0x014 RXDATA RO: pop. Pop when empty returns 0 with error. Write is ignored with error.
  - 0x018 IRQ W1C [0] done: set by core_done_i; set wins over a same-cycle clear. irq_o = done & CTRL[2].
  - Unmapped offsets: read returns 0, write ignored, error.
- Writes to STATUS: ignored, error.
- FIFO full/empty for bus checks are the pre-edge values; a same-cycle core pop does not rescue a full TX push.
- prdata = 0 and pslverr = 0 whenever pready=0.

## Timing
- Reset (synchronous): FSM IDLE, pready 0, pslverr 0, prdata 0, all registers 0, cmd_start_o 0, irq_o 0, FIFOs emptied (tx_empty_o 1, rx_full_o 0). Reset mid-access abandons the transfer with no side effects.
- Latency: setup at T0, pready at T1+WAIT_CYCLES. With WAIT_CYCLES=0 this is a zero-wait APB transfer.
- Register outputs update on the completion edge. cmd_start_o is high for exactly one cycle after that edge.
- Core-side FIFO ports: tx_data_o shows the head entry (first-word fall-through). Pops and pushes take effect on the edge. tx_rd_i when empty and rx_wr_i when full are ignored.
- IRQ set from core_done_i is visible on irq_o one cycle later.

## Configuration
- QSPI_APB_PSLVERR_EN defined: pslverr is driven as above.
- Undefined: pslverr is tied 0. All error cases keep their data behaviour (dropped write, zero read, rejected CMD) silently.

## Structure
- Package qspi_apb_pkg: register offsets, CTRL/STATUS/IRQ bit positions, FSM state encoding.
- Sub-module qspi_sync_fifo: parameterised depth/width, FWFT, level, full and empty outputs. Instantiated twice (TX and RX).

## Test plan
- Reset, then read STATUS → 0x00000004 (tx_empty) plus rx_empty bit → 0x00000014, pready at T1, pslverr 0.
- WAIT_CYCLES=3: write ADDR=0x00ABCDEF → pready at T4, flash_addr_o=0xABCDEF; readback returns 0x00ABCDEF.
- Five TXDATA writes with FIFO_DEPTH=4 → first four accepted (tx level 4, tx_full), fifth gives pslverr=1 and level stays 4. Core pops return the words in order.
- CMD write 0x6B with core_busy_i=0 → cmd_o=0x6B, one-cycle cmd_start_o. Repeat with core_busy_i=1 → pslverr, cmd_o unchanged, no pulse.
- Read RXDATA when empty → 0, pslverr. rx_wr_i 0x12345678, then read → 0x12345678, rx_empty set again.
- CTRL irq_en=1, core_done_i pulse → irq_o=1. W1C to IRQ in the same cycle as a new done pulse → bit stays 1. A later lone W1C → irq_o=0.

Source files
------------

// File: rtl/qspi_apb_pkg.sv
// Shared definitions for the QSPI APB register block: register byte offsets,
// CTRL/STATUS/IRQ bit positions, the APB completer state encoding and a
// STATUS packing helper.
package qspi_apb_pkg;

    // Register byte offsets; paddr[1:0] is ignored by the decoder.
    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_ADDR   = 12'h008;
    localparam logic [11:0] OFF_CMD    = 12'h00C;
    localparam logic [11:0] OFF_TXDATA = 12'h010;
    localparam logic [11:0] OFF_RXDATA = 12'h014;
    localparam logic [11:0] OFF_IRQ    = 12'h018;

    // CTRL: [0] enable, [1] quad, [2] irq_en, [7:4] dummy cycles. Only irq_en
    // is interpreted locally; the rest is consumed by the QSPI engine.
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS bit positions.
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_TX_FULL_BIT  = 1;
    localparam int STAT_TX_EMPTY_BIT = 2;
    localparam int STAT_RX_FULL_BIT  = 3;
    localparam int STAT_RX_EMPTY_BIT = 4;
    localparam int STAT_TX_LVL_LSB   = 8;
    localparam int STAT_RX_LVL_LSB   = 16;
    localparam int LVL_W             = 5;

    // IRQ register: [0] done (write-one-to-clear).
    localparam int IRQ_DONE_BIT = 0;

    // Wait-state counter width (WAIT_CYCLES is 0..15).
    localparam int WAIT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // Assemble the STATUS read value from the live core/FIFO flags.
    function automatic logic [31:0] pack_status(
        input logic             busy,
        input logic             tx_full,
        input logic             tx_empty,
        input logic             rx_full,
        input logic             rx_empty,
        input logic [LVL_W-1:0] tx_lvl,
        input logic [LVL_W-1:0] rx_lvl
    );
        logic [31:0] v;
        v = '0;
        v[STAT_BUSY_BIT]                   = busy;
        v[STAT_TX_FULL_BIT]                = tx_full;
        v[STAT_TX_EMPTY_BIT]               = tx_empty;
        v[STAT_RX_FULL_BIT]                = rx_full;
        v[STAT_RX_EMPTY_BIT]               = rx_empty;
        v[STAT_TX_LVL_LSB +: LVL_W]        = tx_lvl;
        v[STAT_RX_LVL_LSB +: LVL_W]        = rx_lvl;
        return v;
    endfunction

endpackage

// File: rtl/qspi_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data, occupancy level
// and full/empty flags. Pushes when full and pops when empty are ignored.
module qspi_sync_fifo
    import qspi_apb_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_full  = (r_count == LW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_level = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the data array is deliberately not reset; the pointers and count
    // define which entries are valid, and leaving RAM unreset lets it map to
    // plain storage instead of resettable flops.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qspi_apb_regs.sv
// APB completer and register file for the QSPI flash controller: CTRL, STATUS,
// ADDR, CMD, TXDATA/RXDATA FIFO windows and a W1C IRQ register, with a
// programmable number of access-phase wait states.
// Build option: define QSPI_APB_PSLVERR_EN to drive pslverr on error cases;
// otherwise pslverr is tied low and errors are handled silently.
module qspi_apb_regs
    import qspi_apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  ctrl_o,
    output logic [23:0] flash_addr_o,
    output logic [7:0]  cmd_o,
    output logic        cmd_start_o,
    input  logic        core_busy_i,
    input  logic        core_done_i,
    input  logic        tx_rd_i,
    output logic [31:0] tx_data_o,
    output logic        tx_empty_o,
    input  logic        rx_wr_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_full_o,
    output logic        irq_o
);

    localparam int FLW = $clog2(FIFO_DEPTH) + 1;

    apb_state_e        r_state;
    apb_state_e        w_state_next;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_next;
    logic              w_setup;
    logic              w_pready;
    logic              w_commit;

    logic [31:0]       r_prdata;
    logic [7:0]        r_ctrl;
    logic [23:0]       r_addr;
    logic [7:0]        r_cmd;
    logic              r_cmd_start;
    logic              r_irq_done;

    logic [11:0]       w_offset;
    logic [31:0]       w_rdata;
    logic [31:0]       w_status;
    logic              w_err;
    logic              w_wr_commit;
    logic              w_rd_commit;
    logic              w_cmd_accept;
    logic              w_irq_clear;
    logic              w_unused;

    logic              w_tx_push;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [FLW-1:0]    w_tx_level;
    logic              w_rx_pop;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [FLW-1:0]    w_rx_level;
    logic [31:0]       w_rx_data;

    assign w_offset = {paddr[11:2], 2'b00};

    // APB completer state register and wait-state counter.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: setup detection, wait countdown, completion, abort.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_setup      = 1'b0;
        w_pready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_state_next = ST_ACCESS;
                    w_cnt_next   = WAIT_W'(WAIT_CYCLES);
                    w_setup      = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - WAIT_W'(1);
                end else if (penable) begin
                    w_pready     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A reset asserted during the completion cycle abandons the transfer.
    assign w_commit    = w_pready & ~rst;
    assign w_wr_commit = w_commit & pwrite;
    assign w_rd_commit = w_commit & ~pwrite;

    assign w_status = pack_status(core_busy_i, w_tx_full, w_tx_empty,
                                  w_rx_full, w_rx_empty,
                                  LVL_W'(w_tx_level), LVL_W'(w_rx_level));

    // Read data selected at setup time and held in the snapshot register.
    always_comb begin
        w_rdata = '0;
        if (!pwrite) begin
            case (w_offset)
                OFF_CTRL:   w_rdata = {24'b0, r_ctrl};
                OFF_STATUS: w_rdata = w_status;
                OFF_ADDR:   w_rdata = {8'b0, r_addr};
                OFF_CMD:    w_rdata = {24'b0, r_cmd};
                OFF_RXDATA: w_rdata = w_rx_empty ? 32'b0 : w_rx_data;
                OFF_IRQ:    w_rdata[IRQ_DONE_BIT] = r_irq_done;
                default:    ;
            endcase
        end
    end

    // Error classification for the transfer completing this cycle, using the
    // pre-edge FIFO flags.
    always_comb begin
        w_err = 1'b0;
        case (w_offset)
            OFF_CTRL:   w_err = 1'b0;
            OFF_STATUS: w_err = pwrite;
            OFF_ADDR:   w_err = 1'b0;
            OFF_CMD:    w_err = pwrite & core_busy_i;
            OFF_TXDATA: w_err = pwrite ? w_tx_full : 1'b1;
            OFF_RXDATA: w_err = pwrite ? 1'b1 : w_rx_empty;
            OFF_IRQ:    w_err = 1'b0;
            default:    w_err = 1'b1;
        endcase
    end

    assign w_tx_push    = w_wr_commit & (w_offset == OFF_TXDATA) & ~w_tx_full;
    assign w_rx_pop     = w_rd_commit & (w_offset == OFF_RXDATA) & ~w_rx_empty;
    assign w_cmd_accept = w_wr_commit & (w_offset == OFF_CMD) & ~core_busy_i;
    assign w_irq_clear  = w_wr_commit & (w_offset == OFF_IRQ) & pwdata[IRQ_DONE_BIT];

    // Register file updates, read snapshot, command pulse and IRQ flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata    <= '0;
            r_ctrl      <= '0;
            r_addr      <= '0;
            r_cmd       <= '0;
            r_cmd_start <= 1'b0;
            r_irq_done  <= 1'b0;
        end else begin
            r_cmd_start <= w_cmd_accept;
            if (w_setup) begin
                r_prdata <= w_rdata;
            end
            if (w_wr_commit) begin
                case (w_offset)
                    OFF_CTRL: r_ctrl <= pwdata[7:0];
                    OFF_ADDR: r_addr <= pwdata[23:0];
                    default:  ;
                endcase
            end
            if (w_cmd_accept) begin
                r_cmd <= pwdata[7:0];
            end
            // A done pulse wins over a same-cycle W1C.
            if (core_done_i) begin
                r_irq_done <= 1'b1;
            end else if (w_irq_clear) begin
                r_irq_done <= 1'b0;
            end
        end
    end

    qspi_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_data  (pwdata),
        .i_pop   (tx_rd_i),
        .o_data  (tx_data_o),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_level (w_tx_level)
    );

    qspi_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_wr_i),
        .i_data  (rx_data_i),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_level (w_rx_level)
    );

    assign pready       = w_commit;
    assign prdata       = w_commit ? r_prdata : 32'b0;
    assign ctrl_o       = r_ctrl;
    assign flash_addr_o = r_addr;
    assign cmd_o        = r_cmd;
    assign cmd_start_o  = r_cmd_start;
    assign tx_empty_o   = w_tx_empty;
    assign rx_full_o    = w_rx_full;
    assign irq_o        = r_irq_done & r_ctrl[CTRL_IRQ_EN_BIT];

`ifdef QSPI_APB_PSLVERR_EN
    assign pslverr  = w_commit & w_err;
    assign w_unused = ^{paddr[1:0], pwdata[31:24]};
`else
    assign pslverr  = 1'b0;
    assign w_unused = ^{paddr[1:0], pwdata[31:24], w_err};
`endif

endmodule
